// File: rtl/microwire_seq.sv
// Microwire (93xx serial EEPROM) frame sequencer: one command handshake runs a
// full CS/SK/DI frame, samples DO, and polls ready after self-timed cycles.
module microwire_seq #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int unsigned FRAME_W = 3 + ADDR_W + DATA_W;
  localparam int unsigned SR_W    = FRAME_W - 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned PH_W    = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BIT_W-1:0] LAST_ADDR = BIT_W'(2 + ADDR_W);
  localparam logic [BIT_W-1:0] LAST_FULL = BIT_W'(FRAME_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HI     = PH_W'(CLK_DIV);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_OUT, S_SHIFT_IN, S_CS_GAP, S_POLL, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BIT_W-1:0]  last_q, last_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              is_read_q, is_read_d;
  logic              do_poll_q, do_poll_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cs_q, cs_d;
  logic              sk_q, sk_d;
  logic              di_q, di_d;

  // Remaining outgoing bits move up; DO samples enter at the bottom.
  logic [SR_W-1:0] sr_sh;
  assign sr_sh = {sr_q[SR_W-2:0], ee_do};

  // Command decode used at accept time.
  logic [1:0] ext_sel;
  logic       is_wral, is_eral, has_wdata;
  assign ext_sel   = cmd_addr[ADDR_W-1 -: 2];
  assign is_wral   = (cmd_op == OP_EXT) && (ext_sel == 2'b01);
  assign is_eral   = (cmd_op == OP_EXT) && (ext_sel == 2'b10);
  assign has_wdata = (cmd_op == OP_WRITE) || is_wral;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      last_q      <= '0;
      sr_q        <= '0;
      tcnt_q      <= '0;
      is_read_q   <= 1'b0;
      do_poll_q   <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      sk_q        <= 1'b0;
      di_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      last_q      <= last_d;
      sr_q        <= sr_d;
      tcnt_q      <= tcnt_d;
      is_read_q   <= is_read_d;
      do_poll_q   <= do_poll_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cs_q        <= cs_d;
      sk_q        <= sk_d;
      di_q        <= di_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    last_d      = last_q;
    sr_d        = sr_q;
    tcnt_d      = tcnt_q;
    is_read_d   = is_read_q;
    do_poll_d   = do_poll_q;
    err_d       = err_q;
    armed_d     = armed_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    cs_d        = cs_q;
    sk_d        = sk_q;
    di_d        = di_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_SHIFT_OUT;
          phase_d     = '0;
          bit_d       = '0;
          last_d      = (has_wdata || cmd_op == OP_READ) ? LAST_FULL : LAST_ADDR;
          sr_d        = {cmd_op, cmd_addr, has_wdata ? cmd_wdata : DATA_W'(0)};
          is_read_d   = (cmd_op == OP_READ);
          do_poll_d   = has_wdata || is_eral || (cmd_op == OP_ERASE);
          err_d       = 1'b0;
          cmd_ready_d = 1'b0;
          cs_d        = 1'b1;
          sk_d        = 1'b0;
          di_d        = 1'b1;
        end
      end

      S_SHIFT_OUT, S_SHIFT_IN: begin
        if (phase_q == PH_LAST) begin
          sr_d    = sr_sh;
          phase_d = '0;
          sk_d    = 1'b0;
          if (bit_q == last_q) begin
            cs_d = 1'b0;
            di_d = 1'b0;
            if (do_poll_q) begin
              state_d = S_CS_GAP;
            end else begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
              rsp_err_d   = err_q;
              if (is_read_q) rsp_rdata_d = sr_sh[DATA_W-1:0];
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            di_d  = sr_q[SR_W-1];
            // The dummy 0 from the EEPROM arrives on the last address bit.
            if (is_read_q && bit_q == LAST_ADDR) begin
              state_d = S_SHIFT_IN;
              if (ee_do) err_d = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          sk_d    = (phase_q + PH_W'(1)) >= PH_HI;
        end
      end

      S_CS_GAP: begin
        if (phase_q == PH_LAST) begin
          state_d = S_POLL;
          cs_d    = 1'b1;
          armed_d = 1'b0;
          tcnt_d  = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_POLL: begin
        // First CS-high cycle is not sampled; DO needs a cycle to reflect busy.
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (ee_do || tcnt_q == TO_LAST) begin
          state_d     = S_DONE;
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ee_do;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        cs_d        = 1'b0;
        sk_d        = 1'b0;
        di_d        = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ee_cs     = cs_q;
  assign ee_sk     = sk_q;
  assign ee_di     = di_q;

endmodule

// File: tb/tb_microwire_seq.sv
// Directed bench for microwire_seq: frame shape, timing, polling and error paths.
module tb_microwire_seq;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        ee_cs, ee_sk, ee_di, ee_do;

  logic        t_cmd_valid, t_cmd_ready;
  logic [1:0]  t_cmd_op;
  logic [5:0]  t_cmd_addr;
  logic [15:0] t_cmd_wdata;
  logic        t_rsp_valid, t_rsp_err;
  logic [15:0] t_rsp_rdata;
  logic        t_ee_cs, t_ee_sk, t_ee_di, t_ee_do;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  microwire_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di), .ee_do(ee_do)
  );

  microwire_seq #(.TIMEOUT_CYC(16)) dut_t (
    .clk(clk), .rst(rst),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
    .ee_cs(t_ee_cs), .ee_sk(t_ee_sk), .ee_di(t_ee_di), .ee_do(t_ee_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a command in the current cycle; returns in the cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [5:0] addr,
                       input logic [15:0] wd, input logic hold, output int acc);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    acc = cyc;
    tick();
    cmd_valid = hold;
  endtask

  // EEPROM model during a frame: DI captured on each SK rise, DO driven per bit.
  task automatic watch(input logic dummy, input logic [15:0] rd,
                       output int nbits, output logic [31:0] di_bits, output int cs_hi);
    logic prev;
    int guard;
    nbits = 0; di_bits = '0; cs_hi = 0; prev = 1'b0; guard = 0;
    while (ee_cs === 1'b1 && guard < 400) begin
      cs_hi++;
      if (ee_sk && !prev) begin
        di_bits = {di_bits[30:0], ee_di};
        if (nbits == 8) ee_do = dummy;
        else if (nbits >= 9 && nbits <= 24) ee_do = rd[24-nbits];
        else ee_do = 1'b0;
        nbits++;
      end
      prev = ee_sk;
      tick();
      guard++;
    end
    ee_do = 1'b0;
  endtask

  initial begin
    int acc, nb, hi, gap, lat, t_hi;
    logic [31:0] bits;
    logic bad;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0; ee_do = 1'b0;
    t_cmd_valid = 1'b0; t_cmd_op = 2'b00; t_cmd_addr = '0; t_cmd_wdata = '0; t_ee_do = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cs", 32'(ee_cs), 32'd0);
    chk("rst_sk", 32'(ee_sk), 32'd0);
    chk("rst_di", 32'(ee_di), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);

    // READ 0x15 returning 0xBEEF
    issue(2'b10, 6'h15, 16'h0, 1'b0, acc);
    chk("rd_ready_low", 32'(cmd_ready), 32'd0);
    watch(1'b0, 16'hBEEF, nb, bits, hi);
    chk("rd_nbits", 32'(nb), 32'd25);
    chk("rd_hdr", 32'(bits[24:16]), 32'h195);
    chk("rd_di_zero", 32'(bits[15:0]), 32'd0);
    chk("rd_cs_hi", 32'(hi), 32'd100);
    chk("rd_latency", 32'(cyc - acc), 32'd101);
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    chk("rd_data", 32'(rsp_rdata), 32'hBEEF);
    chk("rd_err", 32'(rsp_err), 32'd0);
    tick();
    chk("rd_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("rd_ready_back", 32'(cmd_ready), 32'd1);

    // WRITE 0xA5C3 to 0x3F with 50 busy poll cycles
    issue(2'b01, 6'h3F, 16'hA5C3, 1'b0, acc);
    watch(1'b0, 16'h0, nb, bits, hi);
    chk("wr_nbits", 32'(nb), 32'd25);
    chk("wr_bits", 32'(bits[24:0]), 32'(25'b1_01_111111_1010010111000011));
    chk("wr_no_early_rsp", 32'(rsp_valid), 32'd0);
    gap = 0;
    while (ee_cs === 1'b0 && gap < 20) begin gap++; tick(); end
    chk("wr_cs_gap", 32'(gap), 32'd4);
    chk("wr_poll_sk", 32'(ee_sk), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid !== 1'b0 || ee_cs !== 1'b1) bad = 1'b1;
      tick();
    end
    chk("wr_poll_busy", 32'(bad), 32'd0);
    ee_do = 1'b1;
    tick();
    ee_do = 1'b0;
    chk("wr_valid", 32'(rsp_valid), 32'd1);
    chk("wr_err", 32'(rsp_err), 32'd0);
    chk("wr_cs_off", 32'(ee_cs), 32'd0);
    chk("wr_rdata_kept", 32'(rsp_rdata), 32'hBEEF);
    tick();
    chk("wr_ready_back", 32'(cmd_ready), 32'd1);

    // ERASE with TIMEOUT_CYC=16 and DO stuck low
    t_cmd_op = 2'b11; t_cmd_addr = 6'h05; t_cmd_valid = 1'b1;
    acc = cyc;
    tick();
    t_cmd_valid = 1'b0;
    lat = 0; t_hi = 0;
    while (t_rsp_valid !== 1'b1 && lat < 300) begin
      if (t_ee_cs === 1'b1) t_hi++;
      tick();
      lat++;
    end
    chk("to_latency", 32'(cyc - acc), 32'd58);
    chk("to_cs_hi", 32'(t_hi), 32'd53);
    chk("to_err", 32'(t_rsp_err), 32'd1);
    chk("to_cs_off", 32'(t_ee_cs), 32'd0);
    tick();
    chk("to_ready", 32'(t_cmd_ready), 32'd1);
    chk("to_pulse", 32'(t_rsp_valid), 32'd0);

    // READ with bad dummy bit
    issue(2'b10, 6'h2A, 16'h0, 1'b0, acc);
    watch(1'b1, 16'h1234, nb, bits, hi);
    chk("dm_nbits", 32'(nb), 32'd25);
    chk("dm_valid", 32'(rsp_valid), 32'd1);
    chk("dm_err", 32'(rsp_err), 32'd1);
    chk("dm_data", 32'(rsp_rdata), 32'h1234);
    tick();

    // Reset during bit 5 of a frame
    issue(2'b10, 6'h2A, 16'h0, 1'b0, acc);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cs", 32'(ee_cs), 32'd0);
    chk("mr_sk", 32'(ee_sk), 32'd0);
    chk("mr_di", 32'(ee_di), 32'd0);
    chk("mr_ready", 32'(cmd_ready), 32'd1);
    chk("mr_rdata", 32'(rsp_rdata), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || ee_cs !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("mr_no_rsp", 32'(bad), 32'd0);

    // EWEN after the aborted frame
    issue(2'b00, 6'h30, 16'h0, 1'b0, acc);
    watch(1'b0, 16'h0, nb, bits, hi);
    chk("ew_nbits", 32'(nb), 32'd9);
    chk("ew_bits", 32'(bits[8:0]), 32'h130);
    chk("ew_latency", 32'(cyc - acc), 32'd37);
    chk("ew_valid", 32'(rsp_valid), 32'd1);
    chk("ew_err", 32'(rsp_err), 32'd0);
    tick();

    // cmd_valid held high: one frame per accept
    issue(2'b10, 6'h01, 16'h0, 1'b1, acc);
    watch(1'b0, 16'h00F0, nb, bits, hi);
    chk("hv_cs_hi", 32'(hi), 32'd100);
    chk("hv_valid", 32'(rsp_valid), 32'd1);
    chk("hv_data", 32'(rsp_rdata), 32'h00F0);
    tick();
    chk("hv_ready_after", 32'(cmd_ready), 32'd1);
    chk("hv_cs_idle", 32'(ee_cs), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("hv_second_cs", 32'(ee_cs), 32'd1);
    chk("hv_second_busy", 32'(cmd_ready), 32'd0);
    watch(1'b0, 16'h0F0F, nb, bits, hi);
    chk("hv2_nbits", 32'(nb), 32'd25);
    chk("hv2_data", 32'(rsp_rdata), 32'h0F0F);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ee_cs !== 1'b0) bad = 1'b1;
    end
    chk("hv_no_third", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
